ping_pong_merger: RTL and testbench

- Merges two packetized 512-bit AXI-Stream inputs back into one output stream. Input 0 and input 1 alternate, one group of PACKETS_PER_GROUP packets at a time, starting with input 0.
- It is the receive-side counterpart of the block that splits one frame stream into two ping-pong streams. Together they rebuild the original frame-data order after the two paths are buffered independently.
- A sticky error flag records any disagreement between an input's TLAST and the packet length computed from PACKET_SIZE.

---
 rtl/ping_pong_merger.sv | 118 +++++++++++
 tb/tb_ping_pong_merger.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_merger.sv
// Receive-side ping-pong merger: drains whole packet groups alternately from two
// 512-bit AXI-Stream inputs into one registered output stream, starting with input 0.
module ping_pong_merger (
  input  logic         clk,
  input  logic         reset,

  input  logic [511:0] AXIS_IN0_TDATA,
  input  logic         AXIS_IN0_TLAST,
  input  logic         AXIS_IN0_TVALID,
  output logic         AXIS_IN0_TREADY,

  input  logic [511:0] AXIS_IN1_TDATA,
  input  logic         AXIS_IN1_TLAST,
  input  logic         AXIS_IN1_TVALID,
  output logic         AXIS_IN1_TREADY,

  output logic [511:0] AXIS_OUT_TDATA,
  output logic         AXIS_OUT_TLAST,
  output logic         AXIS_OUT_TVALID,
  input  logic         AXIS_OUT_TREADY,

  input  logic [15:0]  PACKET_SIZE,
  input  logic [31:0]  PACKETS_PER_GROUP,
  input  logic         CLEAR_ERROR,
  output logic         TLAST_ERROR,
  output logic         INPUT_SELECT
);

  logic [7:0]   cpp;
  logic [31:0]  ppg;
  logic [7:0]   beat_count;
  logic [31:0]  packet_count;
  logic         input_select;
  logic         out_valid;
  logic         out_last;
  logic [511:0] out_data;
  logic         tlast_error;

  logic [511:0] sel_data;
  logic         sel_last;
  logic         sel_valid;
  logic         sel_ready;
  logic         accept;
  logic         last_beat;

  // Only bits [13:6] of the byte count matter: beats of 64 bytes, at most 255 per packet.
  logic unused_size_bits;
  assign unused_size_bits = ^{PACKET_SIZE[15:14], PACKET_SIZE[5:0]};

  assign cpp = (PACKET_SIZE[13:6] == 8'd0) ? 8'd1 : PACKET_SIZE[13:6];
  assign ppg = (PACKETS_PER_GROUP == 32'd0) ? 32'd1 : PACKETS_PER_GROUP;

  assign sel_data  = input_select ? AXIS_IN1_TDATA  : AXIS_IN0_TDATA;
  assign sel_last  = input_select ? AXIS_IN1_TLAST  : AXIS_IN0_TLAST;
  assign sel_valid = input_select ? AXIS_IN1_TVALID : AXIS_IN0_TVALID;

  // Single output register without skid buffer: accept only when empty or draining.
  assign sel_ready = (~out_valid | AXIS_OUT_TREADY) & ~reset;
  assign accept    = sel_valid & sel_ready;
  assign last_beat = (beat_count == cpp);

  assign AXIS_IN0_TREADY = ~input_select & sel_ready;
  assign AXIS_IN1_TREADY =  input_select & sel_ready;

  assign AXIS_OUT_TDATA  = out_data;
  assign AXIS_OUT_TLAST  = out_last;
  assign AXIS_OUT_TVALID = out_valid;
  assign TLAST_ERROR     = tlast_error;
  assign INPUT_SELECT    = input_select;

  // NOTE: the data register is reset too, so the output bus reads zero throughout reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_last  <= last_beat;
      out_data  <= sel_data;
    end else if (AXIS_OUT_TREADY) begin
      out_valid <= 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count   <= 8'd1;
      packet_count <= 32'd1;
      input_select <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        beat_count <= 8'd1;
        if (packet_count < ppg) begin
          packet_count <= packet_count + 32'd1;
        end else begin
          packet_count <= 32'd1;
          input_select <= ~input_select;
        end
      end else begin
        beat_count <= beat_count + 8'd1;
      end
    end
  end

  // Clear wins over a same-cycle mismatch; the flag never stalls the data path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tlast_error <= 1'b0;
    end else if (CLEAR_ERROR) begin
      tlast_error <= 1'b0;
    end else if (accept && (sel_last != last_beat)) begin
      tlast_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ping_pong_merger.sv
// Randomized bench for ping_pong_merger: the expected source, TLAST and error flag are
// derived arithmetically from the running count of accepted beats.
module tb_ping_pong_merger;

  localparam int NB = 256;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] AXIS_IN0_TDATA, AXIS_IN1_TDATA, AXIS_OUT_TDATA;
  logic         AXIS_IN0_TLAST, AXIS_IN0_TVALID, AXIS_IN0_TREADY;
  logic         AXIS_IN1_TLAST, AXIS_IN1_TVALID, AXIS_IN1_TREADY;
  logic         AXIS_OUT_TLAST, AXIS_OUT_TVALID, AXIS_OUT_TREADY;
  logic [15:0]  PACKET_SIZE;
  logic [31:0]  PACKETS_PER_GROUP;
  logic         CLEAR_ERROR, TLAST_ERROR, INPUT_SELECT;

  always #5 clk = ~clk;

  ping_pong_merger dut (
    .clk(clk), .reset(reset),
    .AXIS_IN0_TDATA(AXIS_IN0_TDATA), .AXIS_IN0_TLAST(AXIS_IN0_TLAST),
    .AXIS_IN0_TVALID(AXIS_IN0_TVALID), .AXIS_IN0_TREADY(AXIS_IN0_TREADY),
    .AXIS_IN1_TDATA(AXIS_IN1_TDATA), .AXIS_IN1_TLAST(AXIS_IN1_TLAST),
    .AXIS_IN1_TVALID(AXIS_IN1_TVALID), .AXIS_IN1_TREADY(AXIS_IN1_TREADY),
    .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TLAST(AXIS_OUT_TLAST),
    .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
    .PACKET_SIZE(PACKET_SIZE), .PACKETS_PER_GROUP(PACKETS_PER_GROUP),
    .CLEAR_ERROR(CLEAR_ERROR), .TLAST_ERROR(TLAST_ERROR), .INPUT_SELECT(INPUT_SELECT)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // stimulus per input
  logic [511:0] mem [2][NB];
  logic         lst [2][NB];
  int           idx [2];
  logic         vld [2];

  // knobs
  int vprob [2];
  int rmode;
  int starve1;
  int clear_cyc;
  int cyc;
  int cpp_m, ppg_m;

  // reference model
  logic         m_full, m_last, m_err;
  logic [511:0] m_data;
  int           m_acc;

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_inputs();
    AXIS_IN0_TDATA  = mem[0][idx[0] % NB];
    AXIS_IN0_TLAST  = lst[0][idx[0] % NB];
    AXIS_IN0_TVALID = vld[0];
    AXIS_IN1_TDATA  = mem[1][idx[1] % NB];
    AXIS_IN1_TLAST  = lst[1][idx[1] % NB];
    AXIS_IN1_TVALID = vld[1];
  endtask

  task automatic gen_data(int err_beat);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NB; i++) begin
        for (int w = 0; w < 16; w++) mem[k][i][w*32 +: 32] = $urandom;
        lst[k][i] = ((i % cpp_m) == cpp_m - 1);
      end
    end
    if (err_beat >= 0) lst[0][err_beat] = ~lst[0][err_beat];
    apply_inputs();
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_last = 1'b0;
    m_err  = 1'b0;
    m_data = '0;
    m_acc  = 0;
    idx[0] = 0;
    idx[1] = 0;
    cyc    = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_out_valid"}, AXIS_OUT_TVALID, 1'b0);
    check({tag, "_out_last"}, AXIS_OUT_TLAST, 1'b0);
    check({tag, "_out_data"}, AXIS_OUT_TDATA, '0);
    check({tag, "_input_select"}, INPUT_SELECT, 1'b0);
    check({tag, "_in0_ready"}, AXIS_IN0_TREADY, 1'b0);
    check({tag, "_in1_ready"}, AXIS_IN1_TREADY, 1'b0);
  endtask

  task automatic do_reset(int ps, int ppg);
    reset = 1'b1;
    PACKET_SIZE = 16'(ps);
    PACKETS_PER_GROUP = 32'(ppg);
    cpp_m = (ps / 64) % 256;
    if (cpp_m == 0) cpp_m = 1;
    ppg_m = (ppg == 0) ? 1 : ppg;
    model_reset();
    gen_data(-1);
    // valid held high during reset: ready must still stay low
    vld[0] = 1'b1;
    vld[1] = 1'b1;
    apply_inputs();
    AXIS_OUT_TREADY = 1'b1;
    CLEAR_ERROR = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_tlast_error", TLAST_ERROR, 1'b0);
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    apply_inputs();
    reset = 1'b0;
  endtask

  task automatic step();
    int   sel;
    logic exp_rdy, acc, exp_last, mism, hs0, hs1;
    @(negedge clk);
    sel     = (m_acc / cpp_m / ppg_m) % 2;
    exp_rdy = !m_full || AXIS_OUT_TREADY;
    check("out_valid", AXIS_OUT_TVALID, m_full);
    if (m_full) begin
      check("out_data", AXIS_OUT_TDATA, m_data);
      check("out_last", AXIS_OUT_TLAST, m_last);
    end
    check("input_select", INPUT_SELECT, sel[0]);
    check("tlast_error", TLAST_ERROR, m_err);
    check("in0_ready", AXIS_IN0_TREADY, (sel == 0) && exp_rdy);
    check("in1_ready", AXIS_IN1_TREADY, (sel == 1) && exp_rdy);
    hs0 = AXIS_IN0_TVALID && AXIS_IN0_TREADY;
    hs1 = AXIS_IN1_TVALID && AXIS_IN1_TREADY;

    acc  = vld[sel] && exp_rdy;
    mism = 1'b0;
    if (acc) begin
      exp_last = ((m_acc % cpp_m) == cpp_m - 1);
      mism     = (lst[sel][idx[sel] % NB] != exp_last);
      m_data   = mem[sel][idx[sel] % NB];
      m_last   = exp_last;
      m_full   = 1'b1;
      m_acc++;
    end else if (AXIS_OUT_TREADY) begin
      m_full = 1'b0;
    end
    if (CLEAR_ERROR) m_err = 1'b0;
    else if (mism)   m_err = 1'b1;

    @(posedge clk);
    #1;
    cyc++;
    if (hs0) idx[0]++;
    if (hs1) idx[1]++;
    for (int k = 0; k < 2; k++) begin
      if (!vld[k] || (k == 0 ? hs0 : hs1))
        vld[k] = (idx[k] < NB) && !(k == 1 && cyc < starve1) &&
                 ($urandom_range(99) < vprob[k]);
    end
    case (rmode)
      0:       AXIS_OUT_TREADY = 1'b1;
      1:       AXIS_OUT_TREADY = ~AXIS_OUT_TREADY;
      default: AXIS_OUT_TREADY = ($urandom_range(99) < 70);
    endcase
    CLEAR_ERROR = (cyc == clear_cyc);
    apply_inputs();
  endtask

  task automatic set_knobs(int p0, int p1, int rm, int st, int clr);
    vprob[0]  = p0;
    vprob[1]  = p1;
    rmode     = rm;
    starve1   = st;
    clear_cyc = clr;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vld[0] = 1'b0;
    vld[1] = 1'b0;

    // nominal merge: cpp=4, ppg=2, full rate
    set_knobs(100, 100, 0, 0, -1);
    do_reset(256, 2);
    repeat (60) step();

    // backpressure: downstream ready toggles every clock
    set_knobs(100, 100, 1, 0, -1);
    do_reset(256, 2);
    repeat (80) step();

    // starved input 1 after input 0 completes its group
    set_knobs(100, 100, 0, 30, -1);
    do_reset(256, 2);
    repeat (60) step();

    // TLAST error on 3rd beat of input 0, cleared later
    set_knobs(100, 100, 0, 0, 20);
    do_reset(256, 2);
    gen_data(2);
    repeat (40) step();
    check("error_cleared", TLAST_ERROR, 1'b0);

    // degenerate: cpp=1, ppg=1 -> alternate every beat
    set_knobs(80, 80, 2, 0, -1);
    do_reset(32, 0);
    repeat (80) step();

    // random configurations with random valid / ready
    for (int r = 0; r < 4; r++) begin
      set_knobs(70, 70, 2, 0, -1);
      do_reset(64 * $urandom_range(1, 6), $urandom_range(1, 3));
      repeat (150) step();
    end

    // async reset mid-packet after 2 beats of input 1
    set_knobs(100, 100, 0, 0, -1);
    do_reset(256, 1);
    for (int n = 0; n < 50 && m_acc < 6; n++) step();
    check("mid_reset_reached", (m_acc >= 6), 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    apply_inputs();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
